// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      D_ACC = 2'd1,
      I_ACC = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   typedef enum logic {
      GRANT_IF  = 1'b0,
      GRANT_MEM = 1'b1
   } grant_e;

   localparam int CNT_W         = 4;
   localparam int SRAM_WAIT_MIN = 1;
   localparam int SRAM_WAIT_MAX = 15;

   function automatic logic wait_ok(input int w);
      return (w >= SRAM_WAIT_MIN) && (w <= SRAM_WAIT_MAX);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Access wait counter: clear on load, count on enable, flag the last wait cycle.
module sram_wait_timer
   import mem_arb_pkg::*;
#(
   parameter int SRAM_WAIT = 4
) (
   input  logic clk,
   input  logic rest,
   input  logic load_i,
   input  logic en_i,
   output logic tc_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rest)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == CNT_W'(SRAM_WAIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency SRAM port between IF and MEM.
// Optional stall performance counters: define MEM_ARB_STALL_CNT_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int SRAM_WAIT = 4
) (
   input  logic              clk,
   input  logic              rest,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              mem_r_en,
   input  logic              mem_w_en,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ack,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   output logic              sram_we,
   output logic              sram_oe,
   input  logic [DATA_W-1:0] sram_rdata,
`ifdef MEM_ARB_STALL_CNT_EN
   output logic [31:0]       perf_if_stall,
   output logic [31:0]       perf_mem_stall,
`endif
   output logic              freeze_if,
   output logic              stall_mem
);

   if (!wait_ok(SRAM_WAIT)) begin : g_bad_wait
      $error("mem_port_arbiter: SRAM_WAIT out of range 1..15");
   end

   arb_state_e        state_q;
   grant_e            last_grant_q;
   logic [ADDR_W-1:0] sram_addr_q;
   logic [DATA_W-1:0] sram_wdata_q;
   logic              sram_we_q, sram_oe_q;
   logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
   logic              if_ack_q, mem_ack_q;
   logic              mem_pend, grant_mem, in_acc, tc;

   assign mem_pend  = mem_r_en | mem_w_en;
   // On a tie the side that did not win last time gets the port.
   assign grant_mem = mem_pend & (~if_req | (last_grant_q == GRANT_IF));
   assign in_acc    = (state_q == D_ACC) | (state_q == I_ACC);

   sram_wait_timer #(.SRAM_WAIT(SRAM_WAIT)) u_timer (
      .clk    (clk),
      .rest   (rest),
      .load_i (~in_acc),
      .en_i   (in_acc),
      .tc_o   (tc)
   );

   always_ff @(posedge clk) begin
      if (rest) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_IF;
         sram_addr_q  <= '0;
         sram_wdata_q <= '0;
         sram_we_q    <= 1'b0;
         sram_oe_q    <= 1'b0;
         if_rdata_q   <= '0;
         mem_rdata_q  <= '0;
         if_ack_q     <= 1'b0;
         mem_ack_q    <= 1'b0;
      end else begin
         if_ack_q  <= 1'b0;
         mem_ack_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (grant_mem) begin
                  state_q      <= D_ACC;
                  sram_addr_q  <= mem_addr;
                  sram_wdata_q <= mem_wdata;
                  sram_we_q    <= mem_w_en;
                  sram_oe_q    <= ~mem_w_en;
               end else if (if_req) begin
                  state_q     <= I_ACC;
                  sram_addr_q <= if_addr;
                  sram_we_q   <= 1'b0;
                  sram_oe_q   <= 1'b1;
               end
            end
            D_ACC: begin
               if (tc) begin
                  state_q      <= RESP;
                  last_grant_q <= GRANT_MEM;
                  mem_ack_q    <= 1'b1;
                  sram_we_q    <= 1'b0;
                  sram_oe_q    <= 1'b0;
                  if (!sram_we_q)
                     mem_rdata_q <= sram_rdata;
               end
            end
            I_ACC: begin
               if (tc) begin
                  state_q      <= RESP;
                  last_grant_q <= GRANT_IF;
                  if_ack_q     <= 1'b1;
                  sram_oe_q    <= 1'b0;
                  if_rdata_q   <= sram_rdata;
               end
            end
            RESP: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign if_rdata   = if_rdata_q;
   assign if_ack     = if_ack_q;
   assign mem_rdata  = mem_rdata_q;
   assign mem_ack    = mem_ack_q;
   assign sram_addr  = sram_addr_q;
   assign sram_wdata = sram_wdata_q;
   assign sram_we    = sram_we_q;
   assign sram_oe    = sram_oe_q;
   assign freeze_if  = if_req & ~if_ack_q;
   assign stall_mem  = mem_pend & ~mem_ack_q;

`ifdef MEM_ARB_STALL_CNT_EN
   logic [31:0] perf_if_q, perf_mem_q;

   always_ff @(posedge clk) begin
      if (rest) begin
         perf_if_q  <= '0;
         perf_mem_q <= '0;
      end else begin
         if (freeze_if && (perf_if_q != '1))
            perf_if_q <= perf_if_q + 32'd1;
         if (stall_mem && (perf_mem_q != '1))
            perf_mem_q <= perf_mem_q + 32'd1;
      end
   end

   assign perf_if_stall  = perf_if_q;
   assign perf_mem_stall = perf_mem_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency external data/instruction memory between two requesters: the fetch stage (IF) and the memory stage (MEM, fed by the EXE stage's memREnOut/memWEnOut/ALURes/valRmOut).
- Sequences each access over a fixed number of wait cycles and returns a one-cycle ack.
- Provides stall signals so pipeline control can freeze stages while an access is outstanding.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory port.
- DATA_W, 32, data width.
- SRAM_WAIT, 4, cycles the memory must see a stable request per access; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rest  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request; held high until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_rdata  out  DATA_W  fetched word; valid when if_ack=1.
- if_ack  out  1  one-cycle completion pulse for fetch.
- mem_r_en  in  1  data read request; held until mem_ack.
- mem_w_en  in  1  data write request; held until mem_ack.
- mem_addr  in  ADDR_W  data address (ALU result).
- mem_wdata  in  DATA_W  store data (Rm value).
- mem_rdata  out  DATA_W  load data; valid when mem_ack=1.
- mem_ack  out  1  one-cycle completion pulse for the data access.
- sram_addr  out  ADDR_W  memory address.
- sram_wdata  out  DATA_W  memory write data.
- sram_we  out  1  memory write strobe.
- sram_oe  out  1  memory read enable.
- sram_rdata  in  DATA_W  memory read data.
- freeze_if  out  1  if_req & ~if_ack.
- stall_mem  out  1  (mem_r_en|mem_w_en) & ~mem_ack.

Behaviour:
- FSM states: IDLE, D_ACC, I_ACC, RESP. Wait counter width is 4 bits.
- Reset (rest=1 at an edge, including mid-access):
  - state=IDLE, cnt=0, if_ack=mem_ack=0.
  - if_rdata=mem_rdata=0, sram_we=sram_oe=0, sram_addr=sram_wdata=0, last_grant=IF.
  - Any in-flight access is abandoned. Held requests are re-arbitrated from IDLE.
- IDLE arbitration, sampled each cycle:
  - data pending only -> D_ACC.
  - fetch pending only -> I_ACC.
  - both pending -> grant the requester not in last_grant (round-robin). The first tie after reset goes to data.
- D_ACC/I_ACC:
  - The granted address and data are latched on entry into the sram_* registers and held constant for all SRAM_WAIT cycles.
  - In D_ACC, sram_we = latched mem_w_en and sram_oe = ~sram_we. In I_ACC, sram_oe=1.
  - cnt increments each cycle. When cnt==SRAM_WAIT-1: sram_rdata is captured into the granted rdata register (reads only), the state moves to RESP, and last_grant is updated.
- RESP:
  - Exactly one cycle; the granted ack=1 and sram_we/sram_oe=0.
  - Requests are ignored in this cycle. The next state is IDLE.
- Latency: request first seen in cycle 0 -> access cycles 1..SRAM_WAIT -> ack in cycle SRAM_WAIT+1. Back-to-back accesses have a minimum spacing of SRAM_WAIT+2 cycles.
- Writes: mem_ack pulses; mem_rdata retains its previous value.
- mem_r_en and mem_w_en both high: treated as a write.
- if_rdata and mem_rdata hold their value until the next completed read of the same requester.
- freeze_if and stall_mem are combinational from the inputs and the ack registers. Neither is ever high in the requester's own ack cycle.

Optional Feature:
- Macro: MEM_ARB_STALL_CNT_EN.
- When defined, adds two outputs, perf_if_stall and perf_mem_stall, each 32 bits.
  - They count cycles in which freeze_if (resp. stall_mem) is 1.
  - Both saturate at 0xFFFF_FFFF and clear on rest.
- When undefined, neither the ports nor the counters exist. Behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg: FSM state encoding (IDLE=0, D_ACC=1, I_ACC=2, RESP=3), grant encoding (GRANT_IF=0, GRANT_MEM=1), and the SRAM_WAIT range-check constant.
- One sub-module, sram_wait_timer: load/enable, terminal-count flag at SRAM_WAIT-1, synchronous clear on rest.

Test Plan:
- SRAM_WAIT=4; if_req=1, if_addr=0x10 at cycle 0, memory returns 0xE3A0_0001 -> sram_oe=1 and sram_addr=0x10 in cycles 1-4; if_ack=1 and if_rdata=0xE3A0_0001 at cycle 5; freeze_if=1 in cycles 0-4.
- mem_w_en=1, mem_addr=0x400, mem_wdata=0xDEAD_BEEF -> sram_we=1 for exactly 4 cycles with stable address and data; mem_ack at cycle 5; mem_rdata unchanged.
- if_req and mem_r_en both high continuously from reset release -> grant order MEM, IF, MEM, IF; acks spaced 6 cycles apart.
- rest asserted in the 2nd D_ACC cycle -> next cycle state=IDLE, sram_we=0, no ack; the held request restarts and acks 5 cycles after rest drops.
- SRAM_WAIT=1 single read -> ack at cycle 2; mem_r_en and mem_w_en both high -> a write is performed.
- With MEM_ARB_STALL_CNT_EN, a single 4-wait fetch -> perf_if_stall=5; perf_mem_stall=0.
